ram512_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of one single-port RAM512 (512 x 16, write on clk edge when load=1, combinational read of the addressed word).
- Lets requester A (CPU data port) and requester B (DMA / screen-refresh port) share the RAM without conflict.
- Includes a bulk-clear engine that writes CLEAR_VAL into all 512 words on command.
- Sits between the requesters and the RAM512 instance; drives all RAM512 inputs.

---
 rtl/ram512_arbiter.sv | 112 +++++++++++
 tb/tb_ram512_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram512_arbiter.sv
// rtl/ram512_arbiter.sv - round-robin two-port arbiter and bulk-clear sequencer for a RAM512
module ram512_arbiter #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 9,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out
);

   typedef enum logic {SERVE, CLEAR} state_t;

   state_t            state;
   logic              prio_b;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_in;
   logic              serve_ok;

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   assign serve_ok = rst_n && (state == SERVE) && !clear_start;
   assign a_gnt    = serve_ok && a_req && (!b_req || !prio_b);
   assign b_gnt    = serve_ok && b_req && (!a_req || prio_b);

   always_comb begin
      ram_addr = last_addr;
      ram_in   = last_in;
      ram_load = 1'b0;
      if (state == CLEAR) begin
         ram_addr = cnt;
         ram_in   = CLEAR_VAL;
         ram_load = 1'b1;
      end else if (a_gnt) begin
         ram_addr = a_addr;
         ram_in   = a_wdata;
         ram_load = a_we;
      end else if (b_gnt) begin
         ram_addr = b_addr;
         ram_in   = b_wdata;
         ram_load = b_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SERVE;
         prio_b     <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         clear_done <= 1'b0;
         a_rvalid   <= 1'b0;
         b_rvalid   <= 1'b0;
         a_rdata    <= '0;
         b_rdata    <= '0;
         last_addr  <= '0;
         last_in    <= '0;
      end else begin
         a_rvalid   <= a_gnt && !a_we;
         b_rvalid   <= b_gnt && !b_we;
         if (a_gnt && !a_we) a_rdata <= ram_out;
         if (b_gnt && !b_we) b_rdata <= ram_out;
         last_addr  <= ram_addr;
         last_in    <= ram_in;
         clear_done <= 1'b0;
         case (state)
            SERVE: begin
               if (clear_start) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else if (a_gnt) begin
                  prio_b <= 1'b1;
               end else if (b_gnt) begin
                  prio_b <= 1'b0;
               end
            end
            CLEAR: begin
               // Counter wraps to zero on its own after the last address.
               cnt <= cnt + 1'b1;
               if (cnt == {ADDR_W{1'b1}}) begin
                  state      <= SERVE;
                  busy       <= 1'b0;
                  clear_done <= 1'b1;
               end
            end
            default: state <= SERVE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram512_arbiter.sv
// tb/tb_ram512_arbiter.sv - bench for ram512_arbiter with a RAM512 behavioural memory
module tb_ram512_arbiter;
   localparam int DW = 16;
   localparam int AW = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          a_req, a_we, b_req, b_we, clear_start;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid, busy, clear_done, ram_load;
   logic [DW-1:0] a_rdata, b_rdata, ram_in, ram_out;
   logic [AW-1:0] ram_addr;

   ram512_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
      .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out)
   );

   // RAM512: write on clock edge, combinational read; zero-filled at the first edge
   logic [DW-1:0] mem [512];
   bit            mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 512; i++) mem[i] <= '0;
         mem_ready <= 1'b1;
      end else if (ram_load) begin
         mem[ram_addr] <= ram_in;
      end
   end
   assign ram_out = mem[ram_addr];

   typedef struct {
      logic          a_req, a_we;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_wdata;
      logic          b_req, b_we;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_wdata;
      logic          clr;
      logic          ag, bg, arv, brv;
      logic [DW-1:0] ard, brd;
   } vec_t;

   int compared;
   int mismatched;

   logic [DW-1:0] ref_mem [512];
   bit            ref_ptr_b;
   int            ref_left;
   logic          e_arv, e_brv, e_busy, e_done;
   logic [DW-1:0] e_ard, e_brd;
   bit            last_ga, last_gb;

   function automatic vec_t mk(input int ar, aw, aa, ad, br, bw, ba, bd, clr,
                               input int ag, bg, arv, brv, ard, brd);
      vec_t v;
      v.a_req = 1'(ar); v.a_we = 1'(aw); v.a_addr = 9'(aa); v.a_wdata = 16'(ad);
      v.b_req = 1'(br); v.b_we = 1'(bw); v.b_addr = 9'(ba); v.b_wdata = 16'(bd);
      v.clr = 1'(clr);
      v.ag = 1'(ag); v.bg = 1'(bg); v.arv = 1'(arv); v.brv = 1'(brv);
      v.ard = 16'(ard); v.brd = 16'(brd);
      return v;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic ref_reset();
      ref_ptr_b = 1'b0; ref_left = 0;
      e_arv = 1'b0; e_brv = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      e_ard = '0; e_brd = '0;
   endtask

   // One clock: drive at negedge, check grants mid-cycle, check registered outputs after posedge.
   task automatic step(input vec_t v, input bit tbl_chk);
      logic ga, gb;
      @(negedge clk);
      a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
      b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
      clear_start = v.clr;
      #1;
      ga = 1'b0; gb = 1'b0;
      if (ref_left == 0 && !v.clr) begin
         if (v.a_req && (!v.b_req || !ref_ptr_b)) ga = 1'b1;
         else if (v.b_req) gb = 1'b1;
      end
      chk1("a_gnt", a_gnt, ga);
      chk1("b_gnt", b_gnt, gb);
      if (tbl_chk) begin
         chk1("tbl_a_gnt", a_gnt, v.ag);
         chk1("tbl_b_gnt", b_gnt, v.bg);
      end
      if (ga) begin
         chk16("ram_addr_a", 16'(ram_addr), 16'(v.a_addr));
         chk1("ram_load_a", ram_load, v.a_we);
      end
      if (gb) begin
         chk16("ram_addr_b", 16'(ram_addr), 16'(v.b_addr));
         chk1("ram_load_b", ram_load, v.b_we);
      end
      if (ref_left > 0) begin
         chk16("clr_addr", 16'(ram_addr), 16'(512 - ref_left));
         chk1("clr_load", ram_load, 1'b1);
         chk16("clr_data", ram_in, 16'h0000);
      end
      if (!ga && !gb && ref_left == 0) chk1("idle_load", ram_load, 1'b0);
      e_arv = ga && !v.a_we;
      e_brv = gb && !v.b_we;
      e_done = 1'b0;
      if (e_arv) e_ard = ref_mem[v.a_addr];
      if (e_brv) e_brd = ref_mem[v.b_addr];
      if (ga && v.a_we) ref_mem[v.a_addr] = v.a_wdata;
      if (gb && v.b_we) ref_mem[v.b_addr] = v.b_wdata;
      if (ga) ref_ptr_b = 1'b1;
      if (gb) ref_ptr_b = 1'b0;
      if (ref_left > 0) begin
         ref_mem[512 - ref_left] = 16'h0000;
         ref_left--;
         e_done = (ref_left == 0);
      end else if (v.clr) begin
         ref_left = 512;
      end
      e_busy = (ref_left > 0);
      last_ga = ga; last_gb = gb;
      @(posedge clk);
      #1;
      chk1("a_rvalid", a_rvalid, e_arv);
      chk1("b_rvalid", b_rvalid, e_brv);
      chk16("a_rdata", a_rdata, e_ard);
      chk16("b_rdata", b_rdata, e_brd);
      chk1("busy", busy, e_busy);
      chk1("clear_done", clear_done, e_done);
      if (tbl_chk) begin
         chk1("tbl_a_rvalid", a_rvalid, v.arv);
         chk1("tbl_b_rvalid", b_rvalid, v.brv);
         chk16("tbl_a_rdata", a_rdata, v.ard);
         chk16("tbl_b_rdata", b_rdata, v.brd);
      end
   endtask

   function automatic vec_t wr_a(input int addr, input int data);
      return mk(1, 1, addr, data, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic vec_t rd_a(input int addr, input int clr);
      return mk(1, 0, addr, 0, 0, 0, 0, 0, clr, 0, 0, 0, 0, 0, 0);
   endfunction

   vec_t tbl [15];

   initial begin
      vec_t v, idle;
      int   busy_cnt, done_cnt, done_at;

      compared = 0; mismatched = 0;
      for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0000;
      ref_reset();
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = mk(1, 0, 3, 0,        1, 0, 7, 0,         0, 1, 0, 1, 0, 0, 0);
      tbl[1]  = mk(1, 0, 3, 0,        1, 0, 7, 0,         0, 0, 1, 0, 1, 0, 0);
      tbl[2]  = tbl[0];
      tbl[3]  = tbl[1];
      tbl[4]  = mk(1, 1, 5, 'h1234,   0, 0, 0, 0,         0, 1, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 5, 0,        0, 0, 0, 0,         0, 1, 0, 1, 0, 'h1234, 0);
      tbl[6]  = mk(0, 0, 0, 0,        0, 0, 0, 0,         0, 0, 0, 0, 0, 'h1234, 0);
      tbl[7]  = mk(0, 0, 0, 0,        1, 1, 511, 'hBEEF,  0, 0, 1, 0, 0, 'h1234, 0);
      tbl[8]  = mk(1, 0, 511, 0,      0, 0, 0, 0,         0, 1, 0, 1, 0, 'hBEEF, 0);
      tbl[9]  = mk(1, 1, 511, 'h5555, 1, 0, 511, 0,       0, 0, 1, 0, 1, 'hBEEF, 'hBEEF);
      tbl[10] = mk(1, 1, 511, 'h5555, 0, 0, 0, 0,         0, 1, 0, 0, 0, 'hBEEF, 'hBEEF);
      tbl[11] = mk(0, 0, 0, 0,        1, 0, 511, 0,       0, 0, 1, 0, 1, 'hBEEF, 'h5555);
      tbl[12] = mk(1, 0, 5, 0,        1, 1, 5, 'h9999,    0, 1, 0, 1, 0, 'h1234, 'h5555);
      tbl[13] = mk(1, 0, 5, 0,        1, 1, 5, 'h9999,    0, 0, 1, 0, 0, 'h1234, 'h5555);
      tbl[14] = mk(1, 0, 5, 0,        0, 0, 0, 0,         0, 1, 0, 1, 0, 'h9999, 'h5555);

      // Reset with both requests asserted: nothing may be granted.
      rst_n = 1'b0; clear_start = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_a_gnt", a_gnt, 1'b0);
      chk1("rst_b_gnt", b_gnt, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_clear_done", clear_done, 1'b0);
      chk1("rst_a_rvalid", a_rvalid, 1'b0);
      chk1("rst_b_rvalid", b_rvalid, 1'b0);
      chk16("rst_a_rdata", a_rdata, 16'h0000);
      chk16("rst_b_rdata", b_rdata, 16'h0000);
      chk1("rst_ram_load", ram_load, 1'b0);
      chk16("rst_ram_addr", 16'(ram_addr), 16'h0000);
      chk16("rst_ram_in", ram_in, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;

      for (int i = 0; i < 15; i++) step(tbl[i], 1'b1);

      // Bulk clear with A holding a read request.
      step(wr_a(0, 'hFFFF), 1'b0);
      step(wr_a(256, 'hFFFF), 1'b0);
      step(wr_a(511, 'hFFFF), 1'b0);
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int k = 0; k <= 513; k++) begin
         step(rd_a(0, (k == 0) ? 1 : 0), 1'b0);
         if (busy) busy_cnt++;
         if (clear_done) begin done_cnt++; done_at = k; end
      end
      chkn("clear_busy_cycles", busy_cnt, 512);
      chkn("clear_done_pulses", done_cnt, 1);
      chkn("clear_done_cycle", done_at, 512);
      chk16("clear_rd_0", a_rdata, 16'h0000);
      step(rd_a(256, 0), 1'b0);
      chk16("clear_rd_256", a_rdata, 16'h0000);
      step(rd_a(511, 0), 1'b0);
      chk16("clear_rd_511", a_rdata, 16'h0000);

      // A second clear_start in the middle of a clear changes nothing.
      done_cnt = 0; done_at = -1;
      for (int k = 0; k <= 520; k++) begin
         v = idle;
         v.clr = (k == 0 || k == 100);
         step(v, 1'b0);
         if (clear_done) begin done_cnt++; done_at = k; end
      end
      chkn("restart_done_pulses", done_cnt, 1);
      chkn("restart_done_cycle", done_at, 512);

      // Reset asserted 200 cycles into a clear.
      step(wr_a(300, 'hFFFF), 1'b0);
      step(wr_a(100, 'hFFFF), 1'b0);
      v = idle; v.clr = 1'b1;
      step(v, 1'b0);
      for (int k = 1; k <= 200; k++) step(idle, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_clear_done", clear_done, 1'b0);
      chk1("abort_ram_load", ram_load, 1'b0);
      ref_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(rd_a(300, 0), 1'b0);
      chk16("abort_rd_300", a_rdata, 16'hFFFF);
      step(rd_a(100, 0), 1'b0);
      chk16("abort_rd_100", a_rdata, 16'h0000);

      // Random traffic; a pending request stays unchanged until granted.
      v = idle;
      for (int k = 0; k < 400; k++) begin
         if (!v.a_req || last_ga) begin
            v.a_req   = 1'($urandom_range(0, 1));
            v.a_we    = 1'($urandom_range(0, 1));
            v.a_addr  = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 15));
            v.a_wdata = 16'($urandom);
         end
         if (!v.b_req || last_gb) begin
            v.b_req   = 1'($urandom_range(0, 1));
            v.b_we    = 1'($urandom_range(0, 1));
            v.b_addr  = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 15));
            v.b_wdata = 16'($urandom);
         end
         v.clr = ($urandom_range(0, 99) == 0);
         step(v, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
